mem_access_seq: RTL and testbench
=================================

Name: mem_access_seq

Overview:
- Sequences MEM-stage data accesses (LDR/STR/LDB/STB/LDI/STI) onto the single-port data memory interface.
- Generates byte lanes and extends loaded bytes.
- Performs the two-access indirect sequence: pointer fetch, then data access.
- Stalls the pipeline until the final memory response returns and the load result is registered.

Parameters:
- TIMEOUT_CYCLES, 64: max ACCESS/IND wait cycles before abort; used only with the optional feature.
- ADDR_W, 16: address width.
- DATA_W, 16: data width. Fixed at 16; byte lane logic assumes two lanes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM stage holds a memory instruction.
- req_is_store  in  1  1 = store, 0 = load.
- req_is_byte  in  1  byte access (LDB/STB).
- req_is_ind  in  1  indirect access (LDI/STI).
- req_addr  in  ADDR_W  effective address.
- req_wdata  in  DATA_W  store data; low byte used for STB.
- stall  out  1  freeze pipeline.
- done  out  1  one-cycle pulse: access complete.
- load_data  out  DATA_W  registered load result.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_byte_enable  out  2  lane enables, [0] = low byte.
- mem_rdata  in  DATA_W  memory read data.
- mem_resp  in  1  memory response; completes current strobe.
- err  out  1  timeout flag; tied 0 without the optional feature.

Behaviour:
- Reset: state = IDLE. stall, done, mem_read, mem_write, err = 0. load_data, mem_address, mem_wdata = 0. mem_byte_enable = 2'b11. Reset mid-access drops strobes on the next edge; any pending mem_resp is ignored.
- State IDLE:
  - If req_valid, capture all req_* into internal registers.
  - Go to IND if req_is_ind, else ACCESS.
  - stall = req_valid (combinational).
- State IND:
  - mem_read = 1; mem_address = {cap_addr[15:1], 1'b0}; byte_enable = 11.
  - On mem_resp: cap_addr <= mem_rdata, go to ACCESS.
  - Pointer fetch is always a word read, even for byte-indirect.
  - stall = 1.
- State ACCESS:
  - Word access: mem_address = {cap_addr[15:1], 0}; byte_enable = 11; mem_wdata = cap_wdata.
  - Byte access: mem_address = cap_addr with bit0 kept; byte_enable = 01 if addr[0]=0, else 10; mem_wdata = {cap_wdata[7:0], cap_wdata[7:0]}.
  - Strobe: mem_write = cap_is_store; mem_read = ~cap_is_store. Held constant until mem_resp.
  - On mem_resp:
    - Load: load_data <= word, or zero-extended selected byte (addr[0]=0 takes rdata[7:0], else rdata[15:8]).
    - Store: load_data unchanged.
    - Go to DONE.
  - stall = 1.
- State DONE:
  - done = 1, stall = 0, strobes = 0.
  - Unconditional return to IDLE; a new req_valid is not sampled this cycle.
- Latency from req_valid in IDLE (cycle 0), with memory responding in its first strobe cycle:
  - direct access: DONE at cycle 2.
  - indirect access: DONE at cycle 3.
  - Each extra memory wait cycle adds 1.
- Strobes never both high. mem_resp outside IND/ACCESS is ignored.
- Input changes while not in IDLE are ignored, since the captured copy is used.

Optional Feature:
- Macro: MEM_ACCESS_SEQ_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entry to IND/ACCESS and increments each cycle without mem_resp.
  - When it reaches TIMEOUT_CYCLES: strobes drop, err <= 1 (sticky until rst), state goes to DONE with done = 1. load_data is unchanged.
- When undefined: no counter; err is constant 0; the FSM waits indefinitely.

Test Plan:
- LDR: addr=0x3001, mem_rdata=0xBEEF with resp after 2 wait cycles. Expect mem_address=0x3000, byte_enable=11, mem_read held 3 cycles, done at cycle 4, load_data=0xBEEF.
- LDB high lane: addr=0x1235, rdata=0xA57C, immediate resp. Expect byte_enable=10, load_data=0x00A5, done at cycle 2.
- STB low lane: addr=0x2000, wdata=0x1234. Expect mem_write=1, mem_wdata=0x3434, byte_enable=01, mem_read never asserted.
- LDI: addr=0x4000; pointer read returns 0x5002, data read returns 0x0042. Expect second mem_address=0x5002, load_data=0x0042, done at cycle 3.
- Reset mid-access: rst during ACCESS with mem_read high. Next cycle all strobes=0, stall=0, state IDLE; a subsequent mem_resp produces no done.
- With MEM_ACCESS_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_resp never asserted. Expect err=1 and done pulse 8 cycles after ACCESS entry; err stays 1 until rst.

Source files
------------

// File: rtl/mem_access_seq.sv
// MEM-stage data access sequencer: direct/indirect word and byte accesses on a single-port memory.
// Optional wait timeout enabled with `define MEM_ACCESS_SEQ_TIMEOUT_EN.
module mem_access_seq #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_is_store,
  input  logic              req_is_byte,
  input  logic              req_is_ind,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] load_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_byte_enable,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, IND = 2'd1, ACCESS = 2'd2, DONE = 2'd3} state_t;

  state_t            state_r, state_s;
  logic              cap_is_store_r, cap_is_byte_r;
  logic [ADDR_W-1:0] cap_addr_r;
  logic [DATA_W-1:0] cap_wdata_r;
  logic [DATA_W-1:0] load_data_r;
  logic              timeout_s;
  logic              waiting_s;

  assign waiting_s = (state_r == IND) || (state_r == ACCESS);

`ifdef MEM_ACCESS_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_r;
  logic             err_r;

  assign timeout_s = waiting_s && !mem_resp && (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter restarts whenever a waiting state is entered; err is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
      err_r      <= 1'b0;
    end else begin
      if (state_s != state_r) wait_cnt_r <= '0;
      else if (waiting_s && !mem_resp) wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      if (timeout_s) err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // State register, request capture, pointer update and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      cap_is_store_r <= 1'b0;
      cap_is_byte_r  <= 1'b0;
      cap_addr_r     <= '0;
      cap_wdata_r    <= '0;
      load_data_r    <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            cap_is_store_r <= req_is_store;
            cap_is_byte_r  <= req_is_byte;
            cap_addr_r     <= req_addr;
            cap_wdata_r    <= req_wdata;
          end
        end
        IND: begin
          if (mem_resp) cap_addr_r <= mem_rdata[ADDR_W-1:0];
        end
        ACCESS: begin
          if (mem_resp && !cap_is_store_r) begin
            if (cap_is_byte_r)
              load_data_r <= {8'h00, (cap_addr_r[0] ? mem_rdata[15:8] : mem_rdata[7:0])};
            else
              load_data_r <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and memory interface decode.
  always_comb begin
    state_s         = state_r;
    stall           = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = 2'b11;
    case (state_r)
      IDLE: begin
        stall = req_valid;
        if (req_valid) state_s = req_is_ind ? IND : ACCESS;
        else           state_s = IDLE;
      end
      IND: begin
        stall       = 1'b1;
        mem_read    = 1'b1;
        mem_address = {cap_addr_r[ADDR_W-1:1], 1'b0};
        if (mem_resp)       state_s = ACCESS;
        else if (timeout_s) state_s = DONE;
        else                state_s = IND;
      end
      ACCESS: begin
        stall     = 1'b1;
        mem_write = cap_is_store_r;
        mem_read  = ~cap_is_store_r;
        if (cap_is_byte_r) begin
          mem_address     = cap_addr_r;
          mem_byte_enable = cap_addr_r[0] ? 2'b10 : 2'b01;
          mem_wdata       = {cap_wdata_r[7:0], cap_wdata_r[7:0]};
        end else begin
          mem_address     = {cap_addr_r[ADDR_W-1:1], 1'b0};
          mem_byte_enable = 2'b11;
          mem_wdata       = cap_wdata_r;
        end
        if (mem_resp)       state_s = DONE;
        else if (timeout_s) state_s = DONE;
        else                state_s = ACCESS;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign done      = (state_r == DONE);
  assign load_data = load_data_r;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: a per-cycle expected timeline built from the access rules,
// checked every cycle, plus literal latency/load expectations for each test-plan vector.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_is_store, req_is_byte, req_is_ind;
  logic [15:0] req_addr, req_wdata;
  logic        stall, done, mem_read, mem_write, mem_resp, err;
  logic [15:0] load_data, mem_address, mem_wdata, mem_rdata;
  logic [1:0]  mem_byte_enable;

  mem_access_seq #(.TIMEOUT_CYCLES(8), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_is_store(req_is_store),
    .req_is_byte(req_is_byte), .req_is_ind(req_is_ind), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .done(done), .load_data(load_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, done, rd, wr, err;
    logic [15:0] addr, wdata, ld;
    logic [1:0]  be;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] model_ld = 16'h0000;
  logic        model_err = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
  endtask

  task automatic push(input logic st, dn, rd, wr, input logic [15:0] a, wd, input logic [1:0] be);
    exp_t e;
    e.stall = st; e.done = dn; e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd; e.be = be;
    e.ld = model_ld; e.err = model_err;
    exp_q.push_back(e);
  endtask

  // Per-cycle comparison against the expected timeline.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", {15'd0, stall}, {15'd0, e.stall});
      chk("done", {15'd0, done}, {15'd0, e.done});
      chk("mem_read", {15'd0, mem_read}, {15'd0, e.rd});
      chk("mem_write", {15'd0, mem_write}, {15'd0, e.wr});
      chk("mem_address", mem_address, e.addr);
      chk("mem_wdata", mem_wdata, e.wdata);
      chk("byte_enable", {14'd0, mem_byte_enable}, {14'd0, e.be});
      chk("load_data", load_data, e.ld);
      chk("err", {15'd0, err}, {15'd0, e.err});
    end
  end

  task automatic junk_inputs();
    req_valid = 1'b1; req_is_store = 1'b1; req_is_byte = 1'b1; req_is_ind = 1'b1;
    req_addr = 16'hFFFF; req_wdata = 16'hEEEE;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    req_valid = 1'b0; mem_resp = 1'b0; mem_rdata = 16'hDEAD;
    push(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11);
  endtask

  task automatic run_txn(input logic st, by, ind, input logic [15:0] a, wd,
                         input int pw, input logic [15:0] pdata,
                         input int w, input logic [15:0] rd,
                         input logic [15:0] lit_ld, input int lit_cyc);
    int          cyc;
    logic [15:0] eff;
    cyc = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_store = st; req_is_byte = by; req_is_ind = ind;
    req_addr = a; req_wdata = wd; mem_resp = 1'b0; mem_rdata = 16'hDEAD;
    push(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11);
    eff = a;
    if (ind) begin
      for (int k = 0; k <= pw; k++) begin
        @(posedge clk); #1; cyc++;
        junk_inputs();
        mem_resp  = (k == pw);
        mem_rdata = (k == pw) ? pdata : 16'hDEAD;
        push(1'b1, 1'b0, 1'b1, 1'b0, {a[15:1], 1'b0}, 16'h0000, 2'b11);
      end
      eff = pdata;
    end
    for (int k = 0; k <= w; k++) begin
      @(posedge clk); #1; cyc++;
      junk_inputs();
      mem_resp  = (k == w);
      mem_rdata = (k == w) ? rd : 16'hDEAD;
      push(1'b1, 1'b0, !st, st, by ? eff : {eff[15:1], 1'b0},
           by ? {wd[7:0], wd[7:0]} : wd, by ? (eff[0] ? 2'b10 : 2'b01) : 2'b11);
    end
    if (!st) model_ld = by ? {8'h00, (eff[0] ? rd[15:8] : rd[7:0])} : rd;
    // DONE: a fresh request and a stray response here must both be ignored.
    @(posedge clk); #1; cyc++;
    junk_inputs();
    mem_resp = 1'b1; mem_rdata = 16'h1111;
    push(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11);
    chk("lit_latency", 16'(cyc), 16'(lit_cyc));
    @(negedge clk); #1;
    chk("lit_done", {15'd0, done}, 16'h0001);
    chk("lit_load_data", load_data, lit_ld);
    idle_cycle();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_is_byte = 1'b0; req_is_ind = 1'b0;
    req_addr = 16'h0000; req_wdata = 16'h0000; mem_resp = 1'b0; mem_rdata = 16'h0000;
    @(posedge clk); #1;
    push(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11);
    @(posedge clk); #1;
    mem_resp = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11);
    @(posedge clk); #1;
    rst = 1'b0; mem_resp = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11);
    idle_cycle();

    //      st    by    ind   addr      wdata     pw ptr       w  rdata     lit_ld    lat
    run_txn(1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000, 0, 16'h0000, 2, 16'hBEEF, 16'hBEEF, 4);
    run_txn(1'b0, 1'b1, 1'b0, 16'h1235, 16'h0000, 0, 16'h0000, 0, 16'hA57C, 16'h00A5, 2);
    run_txn(1'b1, 1'b1, 1'b0, 16'h2000, 16'h1234, 0, 16'h0000, 0, 16'h0000, 16'h00A5, 2);
    run_txn(1'b0, 1'b0, 1'b1, 16'h4000, 16'h0000, 0, 16'h5002, 0, 16'h0042, 16'h0042, 3);
    run_txn(1'b1, 1'b1, 1'b1, 16'h6001, 16'hABCD, 1, 16'h7003, 0, 16'h0000, 16'h0042, 4);
    run_txn(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'h0000, 1, 16'h80FF, 16'h00FF, 3);
    run_txn(1'b1, 1'b0, 1'b0, 16'h0007, 16'h5A5A, 0, 16'h0000, 0, 16'h0000, 16'h00FF, 2);

    // Reset while a load is waiting in ACCESS; later responses must not complete anything.
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_store = 1'b0; req_is_byte = 1'b0; req_is_ind = 1'b0;
    req_addr = 16'h0ABC; req_wdata = 16'h0000; mem_resp = 1'b0;
    push(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    push(1'b1, 1'b0, 1'b1, 1'b0, 16'h0ABC, 16'h0000, 2'b11);
    @(posedge clk); #1;
    rst = 1'b0; mem_resp = 1'b1; mem_rdata = 16'h7777;
    model_ld = 16'h0000;
    push(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11);
    @(posedge clk); #1;
    mem_resp = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11);
    @(negedge clk); #1;
    chk("lit_rst_load_data", load_data, 16'h0000);
    chk("lit_rst_no_done", {15'd0, done}, 16'h0000);
    idle_cycle();

`ifdef MEM_ACCESS_SEQ_TIMEOUT_EN
    // No response: eight waiting ACCESS cycles, then DONE with sticky err.
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_store = 1'b0; req_is_byte = 1'b0; req_is_ind = 1'b0;
    req_addr = 16'h0100; mem_resp = 1'b0;
    push(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; mem_resp = 1'b0;
      push(1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b11);
    end
    @(posedge clk); #1;
    model_err = 1'b1;
    push(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11);
    @(negedge clk); #1;
    chk("lit_timeout_err", {15'd0, err}, 16'h0001);
    idle_cycle();
    idle_cycle();
    @(posedge clk); #1;
    rst = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11);
    @(posedge clk); #1;
    rst = 1'b0; model_err = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11);
`endif

    idle_cycle();
    @(posedge clk); #1;
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
